// File: rtl/mby_sb_pkg.sv
// Shared types for the MBY sideband egress path: FSM states, message payload
// struct and the byte-index helper used by the serializer.
package mby_sb_pkg;

  localparam int unsigned SB_MAX_BYTES = 16;
  localparam int unsigned SB_IDX_W     = $clog2(SB_MAX_BYTES);

  typedef enum logic [0:0] {
    SB_IDLE = 1'b0,
    SB_SEND = 1'b1
  } sb_state_e;

  // One buffered sideband message: class, dword count minus 1, raw bytes.
  typedef struct packed {
    logic         np;
    logic [1:0]   dw;
    logic [127:0] data;
  } sb_msg_t;

  // Index of the final byte for a dword-count-minus-1 value: 4*(dw+1)-1.
  function automatic logic [SB_IDX_W-1:0] sb_last_idx(input logic [1:0] dw);
    return {dw, 2'b11};
  endfunction

endpackage

// File: rtl/mby_sb_credit_cnt.sv
// Saturating fabric credit counter.
// Ports: clk/rst_n (async active-low), cup_i (credit returned), use_i (credit
// consumed), count_o (registered count), ovf_c_o (combinational pulse when a
// return arrives at CRED_MAX without a simultaneous consume).
module mby_sb_credit_cnt #(
  parameter  int unsigned CRED_MAX = 15,
  localparam int unsigned CW       = $clog2(CRED_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cup_i,
  input  logic          use_i,
  output logic [CW-1:0] count_o,
  output logic          ovf_c_o
);

  logic [CW-1:0] count_q, count_d;

  // Return and consume in the same cycle cancel out.
  always_comb begin
    count_d = count_q;
    ovf_c_o = 1'b0;
    if (cup_i && !use_i) begin
      if (count_q == CW'(CRED_MAX)) ovf_c_o = 1'b1;
      else                          count_d = count_q + CW'(1);
    end else if (use_i && !cup_i) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/mby_sb_egress.sv
// Sideband egress serializer: buffers one 1-4 dword message and streams it a
// byte per clock onto the IOSF sideband port once a credit of its class exists.
// Ports: mby_secondary_clock / mby_secondary_reset (async active-low);
//   msg_valid/msg_ready/msg_np/msg_dw/msg_data internal message handshake;
//   mby_sb2_payload/pcput/npput/eom fabric output; sb2_mby_pccup/npcup credit
//   returns; cred_ovf sticky credit overflow; pc_msgs/np_msgs sent counters.
// Build option: MBY_SB_EGRESS_STATS_EN enables the sent-message counters;
//   otherwise pc_msgs/np_msgs are tied to 0.
module mby_sb_egress
  import mby_sb_pkg::*;
#(
  parameter int unsigned CRED_MAX = 15
) (
  input  logic         mby_secondary_clock,
  input  logic         mby_secondary_reset,
  input  logic         tx_enable,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic         msg_np,
  input  logic [1:0]   msg_dw,
  input  logic [127:0] msg_data,
  output logic [7:0]   mby_sb2_payload,
  output logic         mby_sb2_pcput,
  output logic         mby_sb2_npput,
  output logic         mby_sb2_eom,
  input  logic         sb2_mby_pccup,
  input  logic         sb2_mby_npcup,
  output logic         cred_ovf,
  output logic [15:0]  pc_msgs,
  output logic [15:0]  np_msgs
);

  localparam int unsigned CW = $clog2(CRED_MAX + 1);

  logic clk, rst_n;
  assign clk   = mby_secondary_clock;
  assign rst_n = mby_secondary_reset;

  sb_state_e             state_q, state_d;
  logic [SB_IDX_W-1:0]   idx_q, idx_d;
  sb_msg_t               buf_q, buf_d;
  logic                  buf_valid_q, buf_valid_d;
  logic                  msg_ready_q, msg_ready_d;
  logic [7:0]            payload_q, payload_d;
  logic                  pcput_q, pcput_d, npput_q, npput_d, eom_q, eom_d;
  logic                  cred_ovf_q;

  logic [CW-1:0]         pc_cred, np_cred;
  logic                  pc_use, np_use, pc_ovf_c, np_ovf_c;

  sb_msg_t               in_msg, cand, drv;
  logic                  accept, last_byte, cand_valid, start;

  mby_sb_credit_cnt #(.CRED_MAX(CRED_MAX)) u_pc_cnt (
    .clk(clk), .rst_n(rst_n), .cup_i(sb2_mby_pccup), .use_i(pc_use),
    .count_o(pc_cred), .ovf_c_o(pc_ovf_c)
  );

  mby_sb_credit_cnt #(.CRED_MAX(CRED_MAX)) u_np_cnt (
    .clk(clk), .rst_n(rst_n), .cup_i(sb2_mby_npcup), .use_i(np_use),
    .count_o(np_cred), .ovf_c_o(np_ovf_c)
  );

  // Next-state, buffer and registered-output logic.
  // In the final-byte cycle the incoming message bypasses the buffer so that
  // back-to-back messages stream without a bubble.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    payload_d   = '0;
    pcput_d     = 1'b0;
    npput_d     = 1'b0;
    eom_d       = 1'b0;
    pc_use      = 1'b0;
    np_use      = 1'b0;
    in_msg.np   = msg_np;
    in_msg.dw   = msg_dw;
    in_msg.data = msg_data;
    cand        = buf_q;
    drv         = buf_q;
    cand_valid  = 1'b0;
    accept      = msg_valid && msg_ready_q;
    last_byte   = (state_q == SB_SEND) && (idx_q == sb_last_idx(buf_q.dw));

    unique case (state_q)
      SB_IDLE: begin
        cand_valid = buf_valid_q;
        if (accept) begin
          buf_d       = in_msg;
          buf_valid_d = 1'b1;
        end
      end
      SB_SEND: begin
        if (last_byte) begin
          state_d     = SB_IDLE;
          buf_valid_d = accept;
          cand        = in_msg;
          cand_valid  = accept;
          if (accept) buf_d = in_msg;
        end else begin
          idx_d = idx_q + SB_IDX_W'(1);
        end
      end
      default: state_d = SB_IDLE;
    endcase

    start = cand_valid && tx_enable &&
            (cand.np ? (np_cred != '0) : (pc_cred != '0));

    if (start) begin
      state_d = SB_SEND;
      idx_d   = '0;
      drv     = cand;
      pc_use  = !cand.np;
      np_use  = cand.np;
    end

    if (state_d == SB_SEND) begin
      payload_d = drv.data[{idx_d, 3'b000} +: 8];
      pcput_d   = !drv.np;
      npput_d   = drv.np;
      eom_d     = (idx_d == sb_last_idx(drv.dw));
    end

    msg_ready_d = !buf_valid_d ||
                  ((state_d == SB_SEND) && (idx_d == sb_last_idx(buf_d.dw)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SB_IDLE;
      idx_q       <= '0;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      msg_ready_q <= 1'b0;
      payload_q   <= '0;
      pcput_q     <= 1'b0;
      npput_q     <= 1'b0;
      eom_q       <= 1'b0;
      cred_ovf_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      msg_ready_q <= msg_ready_d;
      payload_q   <= payload_d;
      pcput_q     <= pcput_d;
      npput_q     <= npput_d;
      eom_q       <= eom_d;
      cred_ovf_q  <= cred_ovf_q | pc_ovf_c | np_ovf_c;
    end
  end

  assign msg_ready       = msg_ready_q;
  assign mby_sb2_payload = payload_q;
  assign mby_sb2_pcput   = pcput_q;
  assign mby_sb2_npput   = npput_q;
  assign mby_sb2_eom     = eom_q;
  assign cred_ovf        = cred_ovf_q;

`ifdef MBY_SB_EGRESS_STATS_EN
  logic [15:0] pc_msgs_q, np_msgs_q;

  // Count completed messages per class, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_msgs_q <= '0;
      np_msgs_q <= '0;
    end else begin
      if (eom_q && pcput_q && (pc_msgs_q != 16'hFFFF)) pc_msgs_q <= pc_msgs_q + 16'd1;
      if (eom_q && npput_q && (np_msgs_q != 16'hFFFF)) np_msgs_q <= np_msgs_q + 16'd1;
    end
  end

  assign pc_msgs = pc_msgs_q;
  assign np_msgs = np_msgs_q;
`else
  assign pc_msgs = '0;
  assign np_msgs = '0;
`endif

endmodule

// File: tb/tb_mby_sb_egress.sv
// Scoreboard bench for mby_sb_egress: directed messages push expected bytes
// (class, value, eom, optional cycle) into a queue; a negedge monitor pops and
// compares every put cycle and checks idle cycles are quiet.
module tb_mby_sb_egress;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tx_enable = 1'b1;
  logic         msg_valid = 1'b0;
  logic         msg_ready;
  logic         msg_np = 1'b0;
  logic [1:0]   msg_dw = 2'd0;
  logic [127:0] msg_data = '0;
  logic [7:0]   payload;
  logic         pcput, npput, eom;
  logic         pccup = 1'b0, npcup = 1'b0;
  logic         cred_ovf;
  logic [15:0]  pc_msgs, np_msgs;

  mby_sb_egress #(.CRED_MAX(15)) dut (
    .mby_secondary_clock(clk),
    .mby_secondary_reset(rst_n),
    .tx_enable(tx_enable),
    .msg_valid(msg_valid),
    .msg_ready(msg_ready),
    .msg_np(msg_np),
    .msg_dw(msg_dw),
    .msg_data(msg_data),
    .mby_sb2_payload(payload),
    .mby_sb2_pcput(pcput),
    .mby_sb2_npput(npput),
    .mby_sb2_eom(eom),
    .sb2_mby_pccup(pccup),
    .sb2_mby_npcup(npcup),
    .cred_ovf(cred_ovf),
    .pc_msgs(pc_msgs),
    .np_msgs(np_msgs)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       np;
    logic [7:0] b;
    logic       eom;
    int         cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Monitor: every put must match the next expected byte; idle must be quiet.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pcput || npput) begin
        if (q.size() == 0) begin
          fail_now("unexpected_put");
        end else begin
          mon_e = q.pop_front();
          chk("put_class", 64'({pcput, npput}), 64'(mon_e.np ? 2'b01 : 2'b10));
          chk("payload", 64'(payload), 64'(mon_e.b));
          chk("eom", 64'(eom), 64'(mon_e.eom));
          if (mon_e.cyc >= 0) chk("byte_cycle", 64'(cyc), 64'(mon_e.cyc));
        end
      end else begin
        chk("idle_zero", 64'({eom, payload}), 64'(0));
      end
    end
  end

  // Push expected bytes; byte k expected in cycle c0+k unless c0 < 0.
  task automatic push_msg(input logic np, input logic [1:0] dw, input logic [127:0] data,
                          input int nbytes, input int c0);
    exp_t e;
    int   last;
    last = 4 * (int'(dw) + 1) - 1;
    for (int k = 0; k < nbytes; k++) begin
      e.np  = np;
      e.b   = data[8*k +: 8];
      e.eom = (k == last);
      e.cyc = (c0 < 0) ? -1 : c0 + k;
      q.push_back(e);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_reset();
    rst_n = 1'b0; msg_valid = 1'b0; pccup = 1'b0; npcup = 1'b0; tx_enable = 1'b1;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", 64'({msg_ready, pcput, npput, eom, payload, cred_ovf}), 64'(0));
    chk("rst_stats", 64'({pc_msgs, np_msgs}), 64'(0));
    chk("rst_creds", 64'({dut.pc_cred, dut.np_cred}), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 64'(msg_ready), 64'(1));
  endtask

  task automatic cup(input logic np, input int n);
    if (np) npcup = 1'b1; else pccup = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    npcup = 1'b0; pccup = 1'b0;
  endtask

  // Offer a message; h returns the cycle number of the accepting edge.
  task automatic send(input logic np, input logic [1:0] dw, input logic [127:0] data,
                      output int h);
    logic got = 1'b0;
    msg_valid = 1'b1; msg_np = np; msg_dw = dw; msg_data = data;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (msg_ready) begin got = 1'b1; break; end
    end
    @(posedge clk); #1;
    msg_valid = 1'b0;
    h = cyc;
    if (!got) fail_now("msg_ready_timeout");
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) break;
      @(posedge clk); #1;
    end
    if (q.size() != 0) begin
      fail_now("drain_timeout");
      q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, h1, h2, c, exp_pc, exp_np;
    logic [127:0] d;

    // Posted 1-dword message with two credits.
    do_reset();
    cup(1'b0, 2);
    chk("pc_cred_2", 64'(dut.pc_cred), 64'(2));
    d = 128'hDDCCBBAA;
    send(1'b0, 2'd0, d, h);
    push_msg(1'b0, 2'd0, d, 4, h + 1);
    wait_drain();
    chk("pc_cred_after", 64'(dut.pc_cred), 64'(1));

    // Non-posted 4-dword message waiting for a credit; enable drops mid-message.
    do_reset();
    d = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;
    send(1'b1, 2'd3, d, h);
    repeat (10) @(posedge clk);
    #1;
    chk("np_cred_zero", 64'(dut.np_cred), 64'(0));
    c = cyc;
    push_msg(1'b1, 2'd3, d, 16, c + 2);
    cup(1'b1, 1);
    repeat (3) @(posedge clk);
    #1;
    tx_enable = 1'b0;
    wait_drain();
    tx_enable = 1'b1;
    chk("np_cred_used", 64'(dut.np_cred), 64'(0));

    // Back-to-back posted messages, no bubble.
    do_reset();
    cup(1'b0, 2);
    send(1'b0, 2'd0, 128'h44332211, h1);
    push_msg(1'b0, 2'd0, 128'h44332211, 4, h1 + 1);
    send(1'b0, 2'd0, 128'h88776655, h2);
    push_msg(1'b0, 2'd0, 128'h88776655, 4, h2);
    chk("b2b_accept_in_eom", 64'(h2), 64'(h1 + 5));
    wait_drain();
    chk("pc_cred_b2b", 64'(dut.pc_cred), 64'(0));

    // Credit saturation and overflow flag.
    do_reset();
    cup(1'b0, 16);
    chk("pc_cred_sat", 64'(dut.pc_cred), 64'(15));
    chk("cred_ovf_set", 64'(cred_ovf), 64'(1));

    // Return coincident with consume leaves the count unchanged.
    do_reset();
    cup(1'b0, 3);
    send(1'b0, 2'd0, 128'h0BADF00D, h);
    push_msg(1'b0, 2'd0, 128'h0BADF00D, 4, h + 1);
    pccup = 1'b1;
    @(posedge clk); #1;
    pccup = 1'b0;
    chk("pc_cred_cup_use", 64'(dut.pc_cred), 64'(3));
    chk("cred_ovf_clear", 64'(cred_ovf), 64'(0));
    wait_drain();

    // Reset in the middle of a 12-byte message.
    do_reset();
    cup(1'b0, 1);
    d = 128'h0B0A0908_07060504_03020100;
    send(1'b0, 2'd2, d, h);
    push_msg(1'b0, 2'd2, d, 5, h + 1);
    while (cyc < h + 6) begin @(posedge clk); #1; end
    chk("byte5_on_wire", 64'({pcput, payload}), 64'({1'b1, 8'h05}));
    rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", 64'({pcput, npput, eom, payload}), 64'(0));
    chk("queue_empty_at_rst", 64'(q.size()), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("creds_after_rst", 64'({dut.pc_cred, dut.np_cred}), 64'(0));

    // Sent-message counters.
    do_reset();
    cup(1'b0, 3);
    cup(1'b1, 2);
    send(1'b0, 2'd0, 128'h11111111, h); push_msg(1'b0, 2'd0, 128'h11111111, 4, -1);
    send(1'b1, 2'd1, 128'h33333333_22222222, h);
    push_msg(1'b1, 2'd1, 128'h33333333_22222222, 8, -1);
    send(1'b0, 2'd0, 128'h44444444, h); push_msg(1'b0, 2'd0, 128'h44444444, 4, -1);
    send(1'b1, 2'd0, 128'h55555555, h); push_msg(1'b1, 2'd0, 128'h55555555, 4, -1);
    send(1'b0, 2'd0, 128'h66666666, h); push_msg(1'b0, 2'd0, 128'h66666666, 4, -1);
    wait_drain();
    repeat (2) @(posedge clk);
    #1;
`ifdef MBY_SB_EGRESS_STATS_EN
    exp_pc = 3; exp_np = 2;
`else
    exp_pc = 0; exp_np = 0;
`endif
    chk("pc_msgs", 64'(pc_msgs), 64'(exp_pc));
    chk("np_msgs", 64'(np_msgs), 64'(exp_np));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mby_sb_egress.md
# mby_sb_egress

Sideband egress serializer between MBY's internal sideband agent logic and the IOSF sideband fabric port (`mby_sb2_*` / `sb2_mby_*`). It buffers one whole message of 1–4 dwords and tracks posted and non-posted fabric credits. When a credit of the message's class is available, it streams the message one byte per clock onto `mby_sb2_payload`, with `mby_sb2_pcput` or `mby_sb2_npput` asserted and `mby_sb2_eom` on the final byte.

## Interface
- `CRED_MAX`, 15: saturation value of each credit counter; counter width is `$clog2(CRED_MAX+1)`.
- `mby_secondary_clock`  in  1  sideband clock; all state on its rising edge.
- `mby_secondary_reset`  in  1  asynchronous, active-low reset.
- `tx_enable`  in  1  sideband ISM is ACTIVE; gates only the start of a message.
- `msg_valid`  in  1  internal message offered.
- `msg_ready`  out  1  message accepted when `msg_valid && msg_ready`.
- `msg_np`  in  1  1 = non-posted, 0 = posted.
- `msg_dw`  in  2  dword count minus 1 (0 → 4 bytes, 3 → 16 bytes).
- `msg_data`  in  128  message bytes; byte k = `msg_data[8k+7:8k]`.
- `mby_sb2_payload`  out  8  byte on the wire.
- `mby_sb2_pcput`  out  1  posted byte valid.
- `mby_sb2_npput`  out  1  non-posted byte valid.
- `mby_sb2_eom`  out  1  last byte of the message.
- `sb2_mby_pccup`  in  1  one posted credit returned per cycle asserted.
- `sb2_mby_npcup`  in  1  one non-posted credit returned per cycle asserted.
- `cred_ovf`  out  1  sticky flag: a credit was returned while its counter was at `CRED_MAX`.
- `pc_msgs`, `np_msgs`  out  16 each  sent-message counters (only with the stats macro).

## Operation
- Reset values: all outputs 0, both credit counters 0, buffer empty, FSM in IDLE. `msg_ready` is 1 once reset deasserts.
- Buffer: one message register holding class, dword count and data. `msg_ready = !buf_valid || last_byte_cycle`.
- FSM states:
  - IDLE → SEND when `buf_valid && tx_enable && credit[class] != 0`. The credit is consumed on that transition.
  - SEND: drives byte `idx` each cycle. `idx` counts 0 .. `4*(dw+1)-1`. `mby_sb2_eom` is asserted on the final byte.
  - SEND → IDLE after the final byte. If a new message was accepted that same cycle, it is eligible immediately.
- Put signals: exactly one of `mby_sb2_pcput` / `mby_sb2_npput` is high on every SEND cycle, matching the class. Both are low in IDLE.
- Payload and eom: `mby_sb2_payload` and `mby_sb2_eom` are 0 when no put is asserted.
- Credit counters:
  - cup alone: +1, or saturate at `CRED_MAX` and set `cred_ovf`.
  - consume alone: −1.
  - cup and consume in the same cycle: counter unchanged, no overflow flag.
  - Consume never occurs at 0.
- `tx_enable` deasserting mid-message does not stall; the message completes.
- Asynchronous reset mid-message: the buffered message is discarded, outputs go to 0 immediately, and credits return to 0.

## Timing
- Accepted at edge N, with credit and enable present: byte 0 is driven in cycle N+1, and byte k in cycle N+1+k.
- 16-byte message: eom in cycle N+16.
- Back-to-back with credit: the next message's byte 0 follows the previous eom in the very next cycle, with no bubble.
- A cup arriving in cycle C is usable for a start decision in cycle C+1.
- All outputs are registered.

## Configuration
- `MBY_SB_EGRESS_STATS_EN` defined:
  - `pc_msgs` / `np_msgs` increment at each eom of the matching class.
  - They saturate at 16'hFFFF.
  - They reset to 0.
- Not defined: the ports still exist and are tied to 0, with no counter flops.

## Structure
- Package `mby_sb_pkg`:
  - FSM state enum (`SB_IDLE`, `SB_SEND`).
  - `SB_MAX_BYTES = 16`.
  - Message struct type (np, dw, data).
- Sub-module `mby_sb_credit_cnt`: parameterized saturating up/down counter with overflow flag, instanced once for posted and once for non-posted.

## Test plan
- Reset, then 2 `pccup` pulses; send posted 1-dword message with data 32'hDDCCBBAA → payload AA, BB, CC, DD in cycles N+1..N+4, pcput high on all four, eom on DD; posted credit ends at 1.
- Non-posted 4-dword message with np credit 0 → no put for 10 cycles; one `npcup` at cycle C → byte 0 driven at C+2; 16 npput cycles; eom on the 16th.
- Two posted messages offered back-to-back with credit 2 → 8 consecutive pcput cycles, eom at bytes 4 and 8, `msg_ready` high in the first message's eom cycle.
- 16 `pccup` pulses with `CRED_MAX`=15 → counter holds 15 and `cred_ovf` = 1. `pccup` coincident with a message start at credit 3 → credit stays 3.
- Assert reset at byte 5 of a 12-byte message → all puts, eom and payload drop to 0 within the reset cycle; after release, no residual bytes are sent and credits are 0.
- With `MBY_SB_EGRESS_STATS_EN`: send 3 posted and 2 non-posted messages → `pc_msgs` = 3, `np_msgs` = 2. Without the macro, both read 0.
